// File: rtl/fcmp_pkg.sv
// Shared types and constants for the pipelined floating-point compare unit.
package fcmp_pkg;

    typedef enum logic [1:0] {
        FCMP_LT  = 2'b00,
        FCMP_LE  = 2'b01,
        FCMP_EQ  = 2'b10,
        FCMP_MIN = 2'b11
    } fcmp_op_t;

    typedef struct packed {
        logic is_zero;
        logic is_nan;
        logic sign;
    } fcmp_class_t;

    // Canonical quiet NaN {0, all-ones exponent, 1, zeros}; callers cast to their word width.
    function automatic logic [63:0] fcmp_qnan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) v[man_w+i] = 1'b1;
        v[man_w-1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fcmp_if.sv
// Handshake bus of fcmp_pipe: operation request in, compare result out.
interface fcmp_if
    import fcmp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    fcmp_op_t         in_op;
    logic [W-1:0]     in_x1;
    logic [W-1:0]     in_x2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic             out_y;
    logic [W-1:0]     out_val;
    logic [TAG_W-1:0] out_tag;
    logic             out_nan;

    modport master (
        output in_valid, in_op, in_x1, in_x2, in_tag, out_ready,
        input  in_ready, out_valid, out_y, out_val, out_tag, out_nan
    );

    modport slave (
        input  in_valid, in_op, in_x1, in_x2, in_tag, out_ready,
        output in_ready, out_valid, out_y, out_val, out_tag, out_nan
    );

endinterface

// File: rtl/fcmp_core.sv
// Combinational sign-magnitude compare of two packed floats; NaN detection only
// when FCMP_NAN_FLAG_EN is defined.
module fcmp_core
    import fcmp_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic [W-1:0] x1,
    input  logic [W-1:0] x2,
    output logic         lt,
    output logic         eq
`ifdef FCMP_NAN_FLAG_EN
    ,
    output logic [1:0]   nan
`endif
);

    fcmp_class_t c1, c2;
    logic        mlt, meq, any_nan;

    always_comb begin
        c1.sign    = x1[W-1];
        c2.sign    = x2[W-1];
        c1.is_zero = (x1[W-2:0] == '0);
        c2.is_zero = (x2[W-2:0] == '0);
`ifdef FCMP_NAN_FLAG_EN
        c1.is_nan  = (&x1[W-2:MAN_W]) && (x1[MAN_W-1:0] != '0);
        c2.is_nan  = (&x2[W-2:MAN_W]) && (x2[MAN_W-1:0] != '0);
`else
        c1.is_nan  = 1'b0;
        c2.is_nan  = 1'b0;
`endif
    end

    assign mlt     = x1[W-2:0] <  x2[W-2:0];
    assign meq     = x1[W-2:0] == x2[W-2:0];
    assign any_nan = c1.is_nan | c2.is_nan;

    // Signed zeros collapse to one value before any ordering decision.
    always_comb begin
        eq = !any_nan && ((c1.is_zero && c2.is_zero) || (c1.sign == c2.sign && meq));
        lt = 1'b0;
        if (!any_nan && !(c1.is_zero && c2.is_zero)) begin
            if (c1.sign != c2.sign) lt = c1.sign;
            else if (!c1.sign)      lt = mlt;
            else                    lt = !mlt && !meq;
        end
    end

`ifdef FCMP_NAN_FLAG_EN
    assign nan = {c2.is_nan, c1.is_nan};
`endif

endmodule

// File: rtl/fcmp_pipe.sv
// Two-stage pipelined float compare (LT/LE/EQ/MIN) with valid/ready back-pressure.
// Define FCMP_NAN_FLAG_EN for IEEE NaN handling and the out_nan flag.
module fcmp_pipe
    import fcmp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic  clk,
    input  logic  rst,
    fcmp_if.slave bus
);

    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int STAGES = 2;

    logic [STAGES:1]  vld_pipe;
    logic             en;

    logic [W-1:0]     s1_x1, s1_x2;
    fcmp_op_t         s1_op;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_lt, s1_eq;
    logic             c_lt, c_eq;

    logic             s2_y;
    logic [W-1:0]     s2_val;
    logic [TAG_W-1:0] s2_tag;

    logic             r_y;
    logic [W-1:0]     r_val;

`ifdef FCMP_NAN_FLAG_EN
    localparam logic [W-1:0] QNAN = W'(fcmp_qnan(EXP_W, MAN_W));
    logic [1:0] c_nan, s1_nan;
    logic       s2_nan, r_nan;
`endif

    // Whole pipe stalls together; a bubble in S2 still lets the pipe advance.
    assign en            = !vld_pipe[STAGES] || bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.out_y     = s2_y;
    assign bus.out_val   = s2_val;
    assign bus.out_tag   = s2_tag;
`ifdef FCMP_NAN_FLAG_EN
    assign bus.out_nan   = s2_nan;
`else
    assign bus.out_nan   = 1'b0;
`endif

    fcmp_core #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_core (
        .x1  (bus.in_x1),
        .x2  (bus.in_x2),
        .lt  (c_lt),
        .eq  (c_eq)
`ifdef FCMP_NAN_FLAG_EN
        ,
        .nan (c_nan)
`endif
    );

    // Equal operands under MIN keep x1 so min(-0,+0) returns -0 bit-exactly.
    always_comb begin
        r_y   = 1'b0;
        r_val = '0;
`ifdef FCMP_NAN_FLAG_EN
        r_nan = 1'b0;
`endif
        case (s1_op)
            FCMP_LT: r_y = s1_lt;
            FCMP_LE: r_y = s1_lt | s1_eq;
            FCMP_EQ: r_y = s1_eq;
            default: begin
                r_y   = !s1_lt && !s1_eq;
                r_val = r_y ? s1_x2 : s1_x1;
            end
        endcase
`ifdef FCMP_NAN_FLAG_EN
        if (|s1_nan) begin
            r_nan = 1'b1;
            r_y   = 1'b0;
            if (s1_op == FCMP_MIN) begin
                if (&s1_nan) r_val = QNAN;
                else if (s1_nan[0]) begin
                    r_val = s1_x2;
                    r_y   = 1'b1;
                end else r_val = s1_x1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_x1    <= '0;
            s1_x2    <= '0;
            s1_op    <= FCMP_LT;
            s1_tag   <= '0;
            s1_lt    <= 1'b0;
            s1_eq    <= 1'b0;
            s2_y     <= 1'b0;
            s2_val   <= '0;
            s2_tag   <= '0;
`ifdef FCMP_NAN_FLAG_EN
            s1_nan   <= '0;
            s2_nan   <= 1'b0;
`endif
        end else if (en) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};
            s1_x1    <= bus.in_x1;
            s1_x2    <= bus.in_x2;
            s1_op    <= bus.in_op;
            s1_tag   <= bus.in_tag;
            s1_lt    <= c_lt;
            s1_eq    <= c_eq;
            s2_y     <= r_y;
            s2_val   <= r_val;
            s2_tag   <= s1_tag;
`ifdef FCMP_NAN_FLAG_EN
            s1_nan   <= c_nan;
            s2_nan   <= r_nan;
`endif
        end
    end

endmodule
